// File: rtl/branch_seq.sv
// Branch sub-sequencer: computes the branch target, then drives the compare cycle and PC-write condition selects.
// Optional BRANCH_SEQ_STATS_EN adds Zero/Gt inputs and branch/taken event counters.
//
// state | meaning
// IDLE  | waiting for start; all outputs 0
// CALC  | ALUOut <= PC + (offset << 2)
// CMP   | A - B; conditional PC load from ALUOut
// DONE  | completion pulse back to main FSM
// ERR   | non-branch opcode; done + illegal pulse
module branch_seq #(
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_BNE = 6'h05,
  parameter logic [5:0] OP_BLE = 6'h06,
  parameter logic [5:0] OP_BGT = 6'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
`ifdef BRANCH_SEQ_STATS_EN
  input  logic        Zero,
  input  logic        Gt,
  output logic [15:0] taken_cnt,
  output logic [15:0] branch_cnt,
`endif
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  EQorNE,
  output logic [1:0]  GTorLT,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        ALUOutWrite,
  output logic [1:0]  PCSource
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_CMP  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [5:0] op_q;
  logic       is_branch;

  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                     (opcode == OP_BLE) || (opcode == OP_BGT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= 6'd0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) op_q <= opcode;
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    done        = 1'b0;
    illegal     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    EQorNE      = 2'b00;
    GTorLT      = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    ALUOutWrite = 1'b0;
    PCSource    = 2'b00;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = is_branch ? S_CALC : S_ERR;
      end
      S_CALC: begin
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b11;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
        state_nx    = S_CMP;
      end
      S_CMP: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b010;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        if (op_q == OP_BEQ)      EQorNE = 2'b10;
        else if (op_q == OP_BNE) EQorNE = 2'b01;
        else if (op_q == OP_BGT) GTorLT = 2'b10;
        else if (op_q == OP_BLE) GTorLT = 2'b01;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        done     = 1'b1;
        illegal  = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

`ifdef BRANCH_SEQ_STATS_EN
  logic cond_true;

  always_comb begin
    cond_true = 1'b0;
    if (op_q == OP_BEQ)      cond_true = Zero;
    else if (op_q == OP_BNE) cond_true = ~Zero;
    else if (op_q == OP_BGT) cond_true = Gt;
    else if (op_q == OP_BLE) cond_true = ~Gt;
  end

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= 16'd0;
      taken_cnt  <= 16'd0;
    end else if (state == S_CMP) begin
      branch_cnt <= branch_cnt + 16'd1;
      if (cond_true) taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed self-checking bench for branch_seq; stats checks compile only with BRANCH_SEQ_STATS_EN.
module tb_branch_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  opcode;
  logic        busy, done, illegal, PCWrite, PCWriteCond, ALUOutWrite;
  logic [1:0]  EQorNE, GTorLT, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
`ifdef BRANCH_SEQ_STATS_EN
  logic        Zero, Gt;
  logic [15:0] taken_cnt, branch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  branch_seq dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
`ifdef BRANCH_SEQ_STATS_EN
    .Zero(Zero), .Gt(Gt), .taken_cnt(taken_cnt), .branch_cnt(branch_cnt),
`endif
    .busy(busy), .done(done), .illegal(illegal), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .EQorNE(EQorNE), .GTorLT(GTorLT),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ALUOutWrite(ALUOutWrite), .PCSource(PCSource)
  );

  always #5 clk = ~clk;

  // Packed view: busy,done,illegal,PCWrite,PCWriteCond,EQorNE,GTorLT,ALUSrcA,ALUSrcB,ALUOp,ALUOutWrite,PCSource
  logic [18:0] obs;
  assign obs = {busy, done, illegal, PCWrite, PCWriteCond, EQorNE, GTorLT,
                ALUSrcA, ALUSrcB, ALUOp, ALUOutWrite, PCSource};

  localparam logic [18:0] V_IDLE = 19'b0_0_0_0_0_00_00_00_00_000_0_00;
  localparam logic [18:0] V_CALC = 19'b1_0_0_0_0_00_00_00_11_001_1_00;
  localparam logic [18:0] V_DONE = 19'b1_1_0_0_0_00_00_00_00_000_0_00;
  localparam logic [18:0] V_ERR  = 19'b1_1_1_0_0_00_00_00_00_000_0_00;

  function automatic logic [18:0] v_cmp(input logic [1:0] eq, input logic [1:0] gt);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, eq, gt, 2'b01, 2'b00, 3'b010, 1'b0, 2'b01};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_branch_op(input logic [5:0] op, input logic [1:0] eq, input logic [1:0] gt);
    start = 1'b1; opcode = op;
    step();
    start = 1'b0;
    checks++;
    if (obs !== V_CALC) begin errors++; $display("FAIL calc op=%h got=%b exp=%b", op, obs, V_CALC); end
    step();
    checks++;
    if (obs !== v_cmp(eq, gt)) begin errors++; $display("FAIL cmp op=%h got=%b exp=%b", op, obs, v_cmp(eq, gt)); end
    step();
    checks++;
    if (obs !== V_DONE) begin errors++; $display("FAIL done op=%h got=%b exp=%b", op, obs, V_DONE); end
    step();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL idle_after op=%h got=%b exp=%b", op, obs, V_IDLE); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = 6'h00;
    step(); step();
    reset = 1'b0;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs, V_IDLE); end
    start = 1'b1; opcode = 6'h04;
    step();
    start = 1'b0;
    step();
    checks++;
    if (obs !== v_cmp(2'b10, 2'b00)) begin errors++; $display("FAIL pre_reset_cmp got=%b", obs); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL reset_mid_cmp got=%b exp=%b", obs, V_IDLE); end
    step();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL stay_idle_after_reset got=%b exp=%b", obs, V_IDLE); end
    test_branch_op(6'h04, 2'b10, 2'b00);
  endtask

  task automatic test_beq();
    test_branch_op(6'h04, 2'b10, 2'b00);
  endtask

  task automatic test_other_branches();
    test_branch_op(6'h05, 2'b01, 2'b00);
    test_branch_op(6'h07, 2'b00, 2'b10);
    test_branch_op(6'h06, 2'b00, 2'b01);
  endtask

  task automatic test_illegal();
    start = 1'b1; opcode = 6'h23;
    step();
    start = 1'b0;
    checks++;
    if (obs !== V_ERR) begin errors++; $display("FAIL illegal got=%b exp=%b", obs, V_ERR); end
    step();
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL illegal_idle got=%b exp=%b", obs, V_IDLE); end
  endtask

  task automatic test_ignore();
    int dones = 0;
    start = 1'b1; opcode = 6'h04;
    step();
    checks++;
    if (obs !== V_CALC) begin errors++; $display("FAIL ign_calc got=%b exp=%b", obs, V_CALC); end
    start = 1'b1; opcode = 6'h05;
    step();
    start = 1'b0; opcode = 6'h07;
    checks++;
    if (obs !== v_cmp(2'b10, 2'b00)) begin errors++; $display("FAIL ign_cmp got=%b exp=%b", obs, v_cmp(2'b10, 2'b00)); end
    step();
    if (done) dones++;
    checks++;
    if (obs !== V_DONE) begin errors++; $display("FAIL ign_done got=%b exp=%b", obs, V_DONE); end
    // start coincident with done must be dropped
    start = 1'b1; opcode = 6'h04;
    step();
    start = 1'b0;
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL ign_start_on_done got=%b exp=%b", obs, V_IDLE); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    checks++;
    if (obs !== V_IDLE) begin errors++; $display("FAIL ign_final_idle got=%b exp=%b", obs, V_IDLE); end
  endtask

`ifdef BRANCH_SEQ_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", branch_cnt, taken_cnt);
    end
    Zero = 1'b1; Gt = 1'b0;
    test_branch_op(6'h04, 2'b10, 2'b00);
    test_branch_op(6'h05, 2'b01, 2'b00);
    Zero = 1'b0; Gt = 1'b1;
    test_branch_op(6'h07, 2'b00, 2'b10);
    checks++;
    if (branch_cnt !== 16'd3) begin errors++; $display("FAIL stats_branch got=%0d exp=3", branch_cnt); end
    checks++;
    if (taken_cnt !== 16'd2) begin errors++; $display("FAIL stats_taken got=%0d exp=2", taken_cnt); end
    force dut.taken_cnt = 16'hFFFF;
    #1;
    release dut.taken_cnt;
    @(negedge clk);
    Zero = 1'b1;
    test_branch_op(6'h04, 2'b10, 2'b00);
    checks++;
    if (taken_cnt !== 16'd0) begin errors++; $display("FAIL stats_wrap got=%h exp=0000", taken_cnt); end
    checks++;
    if (branch_cnt !== 16'd4) begin errors++; $display("FAIL stats_branch_after_wrap got=%0d exp=4", branch_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'h00;
`ifdef BRANCH_SEQ_STATS_EN
    Zero = 1'b0; Gt = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_beq();
    test_other_branches();
    test_illegal();
    test_ignore();
`ifdef BRANCH_SEQ_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout sim_time=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Branch sub-sequencer of the multicycle control unit.
- Generates PCWrite, PCWriteCond, EQorNE and GTorLT for the PC write-enable combiner. That combiner ORs PCWrite with (PCWriteCond AND selected condition).
- Also drives the datapath ALU and mux selects for the branch-target and compare cycles.
- The main control FSM hands off a decoded branch opcode via a start/done handshake and waits for completion.

Parameters:
- OP_BEQ, 6'h04, opcode for branch-if-equal
- OP_BNE, 6'h05, opcode for branch-if-not-equal
- OP_BLE, 6'h06, opcode for branch-if-less-or-equal
- OP_BGT, 6'h07, opcode for branch-if-greater

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request from the main control FSM; sampled only in IDLE
- opcode  in  6  instruction opcode; valid in the cycle start=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- illegal  out  1  one-cycle pulse, coincident with done, when the opcode is not a branch
- PCWrite  out  1  unconditional PC write; always 0 in this block
- PCWriteCond  out  1  conditional PC write enable
- EQorNE  out  2  condition select: 00 off, 01 take on ~Zero, 10 take on Zero
- GTorLT  out  2  condition select: 00 off, 01 take on ~Gt, 10 take on Gt
- ALUSrcA  out  2  00 PC, 01 reg A
- ALUSrcB  out  2  00 reg B, 11 sign-extended offset << 2
- ALUOp  out  3  000 none, 001 add, 010 sub
- ALUOutWrite  out  1  load ALUOut register
- PCSource  out  2  01 selects ALUOut into PC

Behaviour:
- State machine with states IDLE, CALC, CMP, DONE, ERR. One-hot or binary encoding, implementer's choice.
- Outputs are registered per state (Moore). Every output not listed for a state is 0.
- On reset, and in IDLE: all outputs 0.
- The opcode is latched into an internal register on the accepting cycle. Later changes to the opcode input are ignored until the next accept.
- IDLE:
  - start=1 with a branch opcode goes to CALC.
  - start=1 with any other opcode goes to ERR.
  - start=0 stays in IDLE.
- CALC (1 cycle): computes the branch target.
  - ALUSrcA=00, ALUSrcB=11, ALUOp=001, ALUOutWrite=1.
  - Next state CMP.
- CMP (1 cycle): compares A with B.
  - ALUSrcA=01, ALUSrcB=00, ALUOp=010, PCWriteCond=1, PCSource=01.
  - Condition selects by latched opcode:
    - BEQ: EQorNE=10, GTorLT=00
    - BNE: EQorNE=01, GTorLT=00
    - BGT: EQorNE=00, GTorLT=10
    - BLE: EQorNE=00, GTorLT=01
  - At most one of EQorNE/GTorLT is nonzero.
  - ALUOutWrite=0, so the target stays stable while the PC loads.
  - Next state DONE.
- DONE: done=1, busy=1; next state IDLE.
- ERR: done=1, illegal=1, busy=1. No PC or ALU activity. Next state IDLE.
- Latency: start to done is 3 cycles for a branch (done asserted in the 3rd cycle after the start edge) and 1 cycle for an illegal opcode.
- start while busy: ignored, not queued.
- start in the same cycle done is high: ignored. A new request is accepted only from IDLE, on the cycle after done.
- reset asserted in any state: the next edge forces IDLE with all outputs 0. PCWriteCond must never assert in the cycle after reset.

Optional Feature:
- Macro: BRANCH_SEQ_STATS_EN.
- When defined:
  - Adds inputs Zero and Gt (1 bit each).
  - Adds outputs taken_cnt and branch_cnt (16 bits each).
  - branch_cnt increments on every CMP cycle.
  - taken_cnt increments on CMP when the selected condition is true: BEQ Zero, BNE ~Zero, BGT Gt, BLE ~Gt.
  - Both counters wrap at 16'hFFFF to 0 and clear on reset.
- When undefined: these ports and the counter logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-CMP (assert reset during the CMP cycle) -> next cycle all outputs 0, busy=0; start with 6'h04 then runs normally.
- start, opcode=6'h04 -> CALC (ALUOp=001, ALUOutWrite=1), then CMP (PCWriteCond=1, EQorNE=10, GTorLT=00, PCSource=01), then done=1 on the 3rd cycle, then busy=0.
- Opcodes 6'h05, 6'h07, 6'h06 in turn -> CMP selects EQorNE/GTorLT = 01/00, 00/10, 00/01 respectively; PCWrite=0 throughout.
- start, opcode=6'h23 -> next cycle done=1, illegal=1, PCWriteCond=0, ALUOutWrite=0; then IDLE.
- Second start during CALC, then opcode changed during CMP -> both ignored; exactly one done; CMP selects match the original opcode.
- With BRANCH_SEQ_STATS_EN: BEQ with Zero=1, BNE with Zero=1, BGT with Gt=1 -> branch_cnt=3, taken_cnt=2. Preload-to-wrap case: taken_cnt at 16'hFFFF plus one more taken branch -> 0.
